// File: rtl/mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_copier
// Description : Memory-side block copy engine for the 1K x 32 single-cycle
//               data memory. Copies LENGTH words from SRC to DST in ascending
//               order, one word per three cycles (read, capture, write).
//               Optional feature macro: MEM_BLOCK_COPIER_CHECKSUM_EN adds a
//               running modulo-2^DATA_W sum of every word read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_copier #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memread,
  output logic              mem_memwrite,
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] mem_readdata
);

  // Largest legal copy: the whole memory.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  clamped_len;
  logic              last_word;

  // Oversized requests are clamped to a full-memory copy.
  always_comb begin
    clamped_len = (length > MAX_LEN) ? MAX_LEN : length;
    last_word   = (idx == (len_q - LEN_W'(1)));
  end

  // Copy sequencer; every output is a register updated one cycle ahead of
  // the state it belongs to. mem_writedata doubles as the word buffer: the
  // word captured in CAP is held there and presented during WR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      idx           <= '0;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= clamped_len;
            idx   <= '0;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
            checksum <= '0;
`endif
            if (clamped_len == '0) begin
              // Nothing to move: report completion straight away.
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy        <= 1'b1;
              mem_address <= src_addr;
              mem_memread <= 1'b1;
              state       <= S_RD;
            end
          end
        end

        S_RD: begin
          mem_memread <= 1'b0;
          state       <= S_CAP;
        end

        S_CAP: begin
          mem_writedata <= mem_readdata;
          mem_address   <= dst_q + idx[ADDR_W-1:0];
          mem_memwrite  <= 1'b1;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
          checksum      <= checksum + mem_readdata;
`endif
          state         <= S_WR;
        end

        S_WR: begin
          mem_memwrite <= 1'b0;
          if (last_word) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            mem_address <= '0;
            state       <= S_DONE;
          end else begin
            idx         <= idx + LEN_W'(1);
            // Address arithmetic wraps naturally at ADDR_W bits.
            mem_address <= src_q + idx[ADDR_W-1:0] + ADDR_W'(1);
            mem_memread <= 1'b1;
            state       <= S_RD;
          end
        end

        S_DONE: begin
          // start is not looked at here, so it cannot be accepted on the
          // same edge that returns the engine to IDLE.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_copier
// Description : Self-checking bench for mem_block_copier with a 1K x 32
//               memory model (plus a second bank for cross-memory copies)
//               and an array-based reference model of the copy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_copier;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_readdata;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  mem_block_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .mem_readdata (mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory model: bank A is the data memory; bank B is a second instance
  // that receives writes when to_b is set. load copies pre[] into bank A.
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] pre   [DEPTH];
  logic              load = 1'b0;
  logic              to_b = 1'b0;

  // Single-cycle memory: write on the edge, read data valid the next cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_a[k] <= pre[k];
        mem_b[k] <= '0;
      end
    end else if (mem_memwrite) begin
      if (to_b) mem_b[mem_address] <= mem_writedata;
      else      mem_a[mem_address] <= mem_writedata;
    end
    if (mem_memread) mem_readdata <= mem_a[mem_address];
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_a [DEPTH];
  logic [DATA_W-1:0] ref_b [DEPTH];
  logic [DATA_W-1:0] ref_sum;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ascending word-by-word copy computed on plain arrays.
  task automatic model_copy(input int s, input int d, input int l, input bit tob);
    int n;
    logic [DATA_W-1:0] w;
    n = (l > DEPTH) ? DEPTH : l;
    for (int k = 0; k < DEPTH; k++) begin
      ref_a[k] = pre[k];
      ref_b[k] = '0;
    end
    ref_sum = '0;
    for (int i = 0; i < n; i++) begin
      w = ref_a[(s + i) % DEPTH];
      ref_sum = ref_sum + w;
      if (tob) ref_b[(d + i) % DEPTH] = w;
      else     ref_a[(d + i) % DEPTH] = w;
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mem_a[k] !== ref_a[k]) n++;
      if (mem_b[k] !== ref_b[k]) n++;
    end
    return n;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) pre[k] = $urandom;
  endtask

  task automatic do_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Runs one copy starting from the current (post-edge) time. Cycle 1 is the
  // cycle after the start edge. Optionally pulses a bogus start in ign_cyc.
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input bit tob, input int ign_cyc,
                          output int done_cyc, output int n_wr, output int n_rd,
                          output int n_busy, output int n_both, output int n_done);
    int cyc;
    int tail;
    to_b = tob;
    src_addr = s;
    dst_addr = d;
    length = l;
    start = 1'b1;
    cyc = 0; tail = 0; done_cyc = -1;
    n_wr = 0; n_rd = 0; n_busy = 0; n_both = 0; n_done = 0;
    while (tail < 3 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        src_addr = ~s;
        dst_addr = ~d;
        length = 11'd5;
      end
      if (mem_memwrite) n_wr++;
      if (mem_memread) n_rd++;
      if (busy) n_busy++;
      if (mem_memread && mem_memwrite) n_both++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0) tail++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    bit                tob;
    int                ign;
    int                exp_done;
    int                exp_words;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int dc, nw, nr, nb, nboth, nd;
    int s, d, l;

    vecs[0] = '{"basic",   10'h000, 10'h100, 11'd4,    1'b0, 5,  13,   4};
    vecs[1] = '{"zero",    10'h000, 10'h000, 11'd0,    1'b0, 1,  1,    0};
    vecs[2] = '{"wrap",    10'h3FE, 10'h200, 11'd3,    1'b0, 0,  10,   3};
    vecs[3] = '{"overlap", 10'h010, 10'h011, 11'd3,    1'b0, 10, 10,   3};
    vecs[4] = '{"single",  10'h3FF, 10'h000, 11'd1,    1'b0, 2,  4,    1};
    vecs[5] = '{"full",    10'h000, 10'h000, 11'd1024, 1'b1, 0,  3073, 1024};
    vecs[6] = '{"trunc",   10'h123, 10'h050, 11'd2047, 1'b1, 0,  3073, 1024};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, done, mem_memread, mem_memwrite, mem_address, mem_writedata}, '0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    chk("reset_checksum", checksum, '0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int v = 0; v < 7; v++) begin
      fill_random();
      case (v)
        0: begin
          pre[0] = 32'hC00000F0; pre[1] = 32'h00000F00;
          pre[2] = 32'h0000F000; pre[3] = 32'h000F0000;
        end
        2: begin
          pre[10'h3FE] = 32'h11111111; pre[10'h3FF] = 32'h22222222; pre[0] = 32'h33333333;
        end
        3: pre[10'h10] = 32'hAAAA5555;
        default: ;
      endcase
      do_load();
      model_copy(int'(vecs[v].src), int'(vecs[v].dst), int'(vecs[v].len), vecs[v].tob);
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].tob, vecs[v].ign,
               dc, nw, nr, nb, nboth, nd);
      chk({vecs[v].name, "_done_cycle"}, dc, vecs[v].exp_done);
      chk({vecs[v].name, "_done_count"}, nd, 1);
      chk({vecs[v].name, "_writes"}, nw, vecs[v].exp_words);
      chk({vecs[v].name, "_reads"}, nr, vecs[v].exp_words);
      chk({vecs[v].name, "_busy_cycles"}, nb, 3 * vecs[v].exp_words);
      chk({vecs[v].name, "_rd_wr_overlap"}, nboth, 0);
      chk({vecs[v].name, "_mem"}, mem_diff(), 0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      chk({vecs[v].name, "_checksum"}, checksum, ref_sum);
`endif
      case (v)
        0: begin
          chk("basic_dst3", mem_a[10'h103], 32'h000F0000);
          chk("basic_dst0", mem_a[10'h100], 32'hC00000F0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
          chk("basic_checksum_const", checksum, 32'hC00FFFF0);
`endif
        end
        2: chk("wrap_dst2", mem_a[10'h202], 32'h33333333);
        3: chk("overlap_dst3", mem_a[10'h13], 32'hAAAA5555);
        default: ;
      endcase
    end

    // Randomized copies against the reference model.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      do_load();
      s = $urandom_range(0, DEPTH - 1);
      d = (r % 2 == 0) ? ((s + $urandom_range(0, 4)) % DEPTH) : $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 24);
      model_copy(s, d, l, 1'b0);
      run_copy(ADDR_W'(s), ADDR_W'(d), LEN_W'(l), 1'b0, 0, dc, nw, nr, nb, nboth, nd);
      chk("rand_done_cycle", dc, 3 * l + 1);
      chk("rand_writes", nw, l);
      chk("rand_mem", mem_diff(), 0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      chk("rand_checksum", checksum, ref_sum);
`endif
    end

    // Abort: reset asserted in cycle 5 of a 4-word copy.
    begin
      int cyc = 0;
      int wr_cnt = 0;
      int done_cnt = 0;
      fill_random();
      do_load();
      model_copy(0, 0, 0, 1'b0);
      ref_a[10'h080] = pre[10'h040];
      to_b = 1'b0;
      src_addr = 10'h040; dst_addr = 10'h080; length = 11'd4;
      start = 1'b1;
      while (cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        if (cyc == 6) begin
          chk("abort_outs", {busy, done, mem_memread, mem_memwrite, mem_address, mem_writedata}, '0);
          rst_n = 1'b1;
        end
        if (mem_memwrite) wr_cnt++;
        if (done) done_cnt++;
        if (cyc == 5) rst_n = 1'b0;
      end
      chk("abort_done", done_cnt, 0);
      chk("abort_writes", wr_cnt, 1);
      chk("abort_mem", mem_diff(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Memory-side initiator for the 1K x 32 single-cycle data memory (clk, 10-bit address, writedata, memread, memwrite, readdata).
- Copies a block of words from a source region to a destination region of the same memory.
- Stages CNN feature maps and weights between buffers without CPU load/store loops.
- Sits beside the datapath and owns the memory port while busy; the external arbiter selects it whenever busy=1.

Parameters:
- ADDR_W, 10, word-address width; matches the data memory depth of 1024 words.
- DATA_W, 32, data word width.
- LEN_W, 11, length width; ADDR_W+1 so that a full 1024-word copy is expressible.

Ports:
- clk  in  1  rising-edge clock shared with the data memory.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; latched on an accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on an accepted start.
- length  in  LEN_W  number of words to copy; latched on an accepted start; legal range 0..1024.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle completion pulse.
- mem_address  out  ADDR_W  to the data memory address input.
- mem_writedata  out  DATA_W  to the data memory writedata input.
- mem_memread  out  1  to the data memory memread input.
- mem_memwrite  out  1  to the data memory memwrite input.
- mem_readdata  in  DATA_W  from the data memory readdata output.

Behaviour:
- Reset (rst_n=0 at an edge) forces state IDLE and sets busy, done, mem_memread, mem_memwrite, mem_address and mem_writedata to 0. All outputs are registered.
- Reset mid-copy aborts the transfer: no further memwrite is issued and no done pulse is produced.
- Memory contract: readdata is valid in the cycle after a cycle in which memread=1 with a stable address.
- States:
  - IDLE: if start=1, latch src_addr, dst_addr and length, clear index i, and go to RD. If length=0, go to DONE instead.
  - RD: drive mem_address=src+i and memread=1; go to CAP.
  - CAP: memread=0; register mem_readdata into the word buffer; go to WR.
  - WR: drive mem_address=dst+i, writedata=buffer and memwrite=1. If i=len-1 go to DONE; otherwise i++ and go to RD.
  - DONE: done=1 and busy=0 for exactly one cycle; go to IDLE.
- Cycle numbering: the cycle after the start edge is cycle 1.
  - Word i: RD in cycle 3i+1, CAP in 3i+2, WR in 3i+3.
  - done is asserted in cycle 3L+1.
  - busy=1 in cycles 1..3L.
- memread and memwrite are never high in the same cycle.
- Addresses wrap modulo 2^ADDR_W (src+i and dst+i are truncated to ADDR_W bits).
- Copy order is always ascending. When regions overlap with dst>src, already-written words are re-read; this propagation is the defined behaviour.
- start while busy or in DONE is ignored, not queued.
- start in IDLE on the same edge that DONE→IDLE completes is not accepted; acceptance requires the FSM to already be in IDLE.
- length>1024 is truncated to 1024.

Optional Feature:
- Macro: MEM_BLOCK_COPIER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (DATA_W bits).
  - checksum is cleared on an accepted start.
  - In each CAP cycle, checksum += captured word, modulo 2^DATA_W.
  - checksum holds its final value from the DONE cycle until the next accepted start.
  - checksum resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic copy: preload mem[0..3]=C00000F0, 00000F00, 0000F000, 000F0000; src=0, dst=0x100, len=4 → done in cycle 13; mem[0x100..0x103] equal the source; checksum=C00FFFF0.
- Zero length: start with len=0 → done=1 in cycle 1; busy never high; no memread or memwrite.
- Wrap-around: preload mem[0x3FE]=11111111, mem[0x3FF]=22222222, mem[0]=33333333; src=0x3FE, dst=0x200, len=3 → mem[0x200..0x202]=11111111, 22222222, 33333333.
- Overlap propagation: mem[0x10]=AAAA5555, src=0x10, dst=0x11, len=3 → mem[0x11..0x13] all AAAA5555.
- Abort and ignored start: pulse start during busy → no effect on the current copy. Then assert rst_n=0 in cycle 5 of a len=4 copy → the cycle after, all outputs are 0; no done pulse; only word 0 is written at the destination.
- Handshake integrity: over a full 1024-word copy (src=0, dst=0 of a second memory instance) → memread and memwrite are never both high; exactly 1024 write strobes; done pulses once in cycle 3073.
